// File: rtl/cache_fill_ctrl_if.sv
// Cache-side and memory-side signal bundle for the shared cache fill engine.
// The slave modport is the fill controller's view; master is the environment's view.
interface cache_fill_ctrl_if #(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned NUM_PORTS       = 2
);
    localparam int unsigned WN_W = $clog2(WORDS_PER_BLOCK);

    logic [NUM_PORTS-1:0]        miss;
    logic [NUM_PORTS*ADDR_W-1:0] miss_addr;
    logic [NUM_PORTS-1:0]        grant;
    logic                        busy;
    logic [NUM_PORTS-1:0]        write_data_array;
    logic [NUM_PORTS-1:0]        write_tag_array;
    logic [WN_W-1:0]             word_num;
    logic [DATA_W-1:0]           fill_data;
    logic                        mem_en;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_data;
    logic                        mem_data_valid;

    modport slave (
        input  miss, miss_addr, mem_data, mem_data_valid,
        output grant, busy, write_data_array, write_tag_array,
               word_num, fill_data, mem_en, mem_addr
    );

    modport master (
        output miss, miss_addr, mem_data, mem_data_valid,
        input  grant, busy, write_data_array, write_tag_array,
               word_num, fill_data, mem_en, mem_addr
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Shared block-fill engine for NUM_PORTS caches in front of a pipelined memory.
// Optional feature: define CACHE_FILL_CWF_EN for critical-word-first fill order.
module cache_fill_ctrl #(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned NUM_PORTS       = 2
) (
    input  logic              clk,
    input  logic              rst,
    cache_fill_ctrl_if.slave  bus
);
    localparam int unsigned WN_W  = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned OFF_W = WN_W + 1;

    typedef enum logic {ST_IDLE, ST_FILL} state_t;

    state_t               r_state,     w_state_nxt;
    logic [NUM_PORTS-1:0] r_grant,     w_grant_nxt;
    logic                 r_busy,      w_busy_nxt;
    logic [ADDR_W-1:0]    r_base,      w_base_nxt;
    logic [WN_W-1:0]      r_start,     w_start_nxt;
    logic [OFF_W-1:0]     r_issue_cnt, w_issue_cnt_nxt;
    logic [WN_W-1:0]      r_ret_cnt,   w_ret_cnt_nxt;

    logic                 w_any_miss;
    logic [NUM_PORTS-1:0] w_sel_grant;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [WN_W-1:0]      w_sel_start;
    logic [WN_W-1:0]      w_issue_word;
    logic [WN_W-1:0]      w_ret_word;
    logic                 w_issuing;
    logic                 w_ret_valid;
    logic                 w_ret_last;

    // Fixed-priority arbiter: lowest-index pending miss wins.
    always_comb begin
        w_any_miss  = |bus.miss;
        w_sel_grant = '0;
        w_sel_addr  = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (bus.miss[i]) begin
                w_sel_grant    = '0;
                w_sel_grant[i] = 1'b1;
                w_sel_addr     = bus.miss_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

`ifdef CACHE_FILL_CWF_EN
    assign w_sel_start = w_sel_addr[OFF_W-1:1];
`else
    assign w_sel_start = '0;
`endif

    // Word indices wrap within the block, so the offset never reaches the tag bits.
    assign w_issue_word = r_start + r_issue_cnt[WN_W-1:0];
    assign w_ret_word   = r_start + r_ret_cnt;
    assign w_issuing    = (r_state == ST_FILL) && (r_issue_cnt != OFF_W'(WORDS_PER_BLOCK)) && !rst;
    assign w_ret_valid  = (r_state == ST_FILL) && bus.mem_data_valid && !rst;
    assign w_ret_last   = w_ret_valid && (r_ret_cnt == WN_W'(WORDS_PER_BLOCK - 1));

    // State and fill-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_base      <= '0;
            r_start     <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_busy      <= w_busy_nxt;
            r_base      <= w_base_nxt;
            r_start     <= w_start_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
            r_ret_cnt   <= w_ret_cnt_nxt;
        end
    end

    // Next-state logic: latch the winner in IDLE, count issues and returns in FILL.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_busy_nxt      = r_busy;
        w_base_nxt      = r_base;
        w_start_nxt     = r_start;
        w_issue_cnt_nxt = r_issue_cnt;
        w_ret_cnt_nxt   = r_ret_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any_miss) begin
                    w_state_nxt     = ST_FILL;
                    w_grant_nxt     = w_sel_grant;
                    w_busy_nxt      = 1'b1;
                    w_base_nxt      = {w_sel_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    w_start_nxt     = w_sel_start;
                    w_issue_cnt_nxt = '0;
                    w_ret_cnt_nxt   = '0;
                end
            end
            ST_FILL: begin
                if (w_issuing) begin
                    w_issue_cnt_nxt = r_issue_cnt + OFF_W'(1);
                end
                if (w_ret_valid) begin
                    w_ret_cnt_nxt = r_ret_cnt + WN_W'(1);
                end
                // Last return writes the tag; the following IDLE cycle lets the cache drop miss.
                if (w_ret_last) begin
                    w_state_nxt     = ST_IDLE;
                    w_grant_nxt     = '0;
                    w_busy_nxt      = 1'b0;
                    w_issue_cnt_nxt = '0;
                    w_ret_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.grant            = r_grant;
    assign bus.busy             = r_busy;
    assign bus.write_data_array = w_ret_valid ? r_grant : '0;
    assign bus.write_tag_array  = w_ret_last  ? r_grant : '0;
    assign bus.word_num         = w_ret_valid ? w_ret_word : '0;
    assign bus.fill_data        = bus.mem_data;
    assign bus.mem_en           = w_issuing;
    assign bus.mem_addr         = w_issuing ? (r_base + ADDR_W'({w_issue_word, 1'b0})) : '0;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: default 8-word instance plus a 4-word instance,
// each fed by a 2-cycle-latency memory model.
module tb_cache_fill_ctrl;
`ifdef CACHE_FILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .NUM_PORTS(2)) bus0 ();
    cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(4), .NUM_PORTS(2)) bus1 ();

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .NUM_PORTS(2)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(4), .NUM_PORTS(2)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [1:0]  en_p0, en_p1;
    logic [15:0] a_p0 [2];
    logic [15:0] a_p1 [2];
    int          stray0;

    logic [15:0] iss0[$];
    logic [2:0]  wn0[$];
    logic [1:0]  wm0[$];
    int          tag_idx0, tag_cyc0, en_first0, en_last0, bad0;
    logic [1:0]  tag_m0, grant_after0;
    logic        busy_after0;

    logic [15:0] iss1[$];
    logic [1:0]  wn1[$];
    logic [1:0]  wm1[$];
    int          tag_idx1, tag_cyc1, en_first1, en_last1, bad1;
    logic [1:0]  tag_m1, grant_after1;
    logic        busy_after1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_addr(input logic [15:0] ma, input int wpb, input int k);
        logic [15:0] base;
        int          start;
        base  = ma & ~16'(2 * wpb - 1);
        start = CWF ? (int'(ma >> 1) % wpb) : 0;
        return base + 16'(2 * ((start + k) % wpb));
    endfunction

    function automatic int exp_wn(input logic [15:0] ma, input int wpb, input int k);
        int start;
        start = CWF ? (int'(ma >> 1) % wpb) : 0;
        return (start + k) % wpb;
    endfunction

    task automatic clear_logs();
        iss0.delete(); wn0.delete(); wm0.delete();
        tag_idx0 = -1; tag_cyc0 = -10; en_first0 = -1; en_last0 = -1; bad0 = 0;
        tag_m0 = '0; grant_after0 = '1; busy_after0 = 1'b1;
        iss1.delete(); wn1.delete(); wm1.delete();
        tag_idx1 = -1; tag_cyc1 = -10; en_first1 = -1; en_last1 = -1; bad1 = 0;
        tag_m1 = '0; grant_after1 = '1; busy_after1 = 1'b1;
    endtask

    // One clock: drive memory returns, then observe and log both instances.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (stray0 > 0) begin
            bus0.mem_data_valid = 1'b1;
            bus0.mem_data       = 16'hBEEF;
            stray0--;
        end else begin
            bus0.mem_data_valid = en_p0[1];
            bus0.mem_data       = a_p0[1] ^ 16'h5A5A;
        end
        bus1.mem_data_valid = en_p1[1];
        bus1.mem_data       = a_p1[1] ^ 16'h5A5A;
        #1;
        cyc++;
        if (cyc == tag_cyc0 + 1) begin busy_after0 = bus0.busy; grant_after0 = bus0.grant; end
        if (cyc == tag_cyc1 + 1) begin busy_after1 = bus1.busy; grant_after1 = bus1.grant; end
        if (bus0.mem_en) begin
            if (en_first0 < 0) en_first0 = cyc;
            en_last0 = cyc;
            iss0.push_back(bus0.mem_addr);
        end
        if (bus0.write_data_array != 2'b00) begin
            wn0.push_back(bus0.word_num);
            wm0.push_back(bus0.write_data_array);
            if (bus0.fill_data !== bus0.mem_data) bad0++;
        end
        if (bus0.write_tag_array != 2'b00) begin
            tag_idx0 = wn0.size(); tag_m0 = bus0.write_tag_array; tag_cyc0 = cyc;
            if (bus0.write_data_array !== bus0.write_tag_array) bad0++;
        end
        if (bus1.mem_en) begin
            if (en_first1 < 0) en_first1 = cyc;
            en_last1 = cyc;
            iss1.push_back(bus1.mem_addr);
        end
        if (bus1.write_data_array != 2'b00) begin
            wn1.push_back(bus1.word_num);
            wm1.push_back(bus1.write_data_array);
            if (bus1.fill_data !== bus1.mem_data) bad1++;
        end
        if (bus1.write_tag_array != 2'b00) begin
            tag_idx1 = wn1.size(); tag_m1 = bus1.write_tag_array; tag_cyc1 = cyc;
            if (bus1.write_data_array !== bus1.write_tag_array) bad1++;
        end
        en_p0 = {en_p0[0], bus0.mem_en}; a_p0[1] = a_p0[0]; a_p0[0] = bus0.mem_addr;
        en_p1 = {en_p1[0], bus1.mem_en}; a_p1[1] = a_p1[0]; a_p1[0] = bus1.mem_addr;
    endtask

    task automatic wait_tag(input int d, input int budget);
        int n = 0;
        while ((((d == 0) ? tag_cyc0 : tag_cyc1) < 0) && (n < budget)) begin
            cycle();
            n++;
        end
        chk("tag_seen", 64'(((d == 0) ? tag_cyc0 : tag_cyc1) >= 0), 64'd1);
        cycle();
    endtask

    task automatic wait_wr(input int n_wr, input int budget);
        int n = 0;
        while ((wn0.size() < n_wr) && (n < budget)) begin
            cycle();
            n++;
        end
        chk("wr_seen", 64'(wn0.size()), 64'(n_wr));
    endtask

    task automatic check_fill0(input string nm, input logic [15:0] ma, input logic [1:0] gm);
        chk({nm, "_n_issue"}, 64'(iss0.size()), 64'd8);
        chk({nm, "_en_run"}, 64'(en_last0 - en_first0 + 1), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < iss0.size()) chk({nm, "_addr"}, 64'(iss0[k]), 64'(exp_addr(ma, 8, k)));
        end
        chk({nm, "_n_wr"}, 64'(wn0.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < wn0.size()) begin
                chk({nm, "_word_num"}, 64'(wn0[k]), 64'(exp_wn(ma, 8, k)));
                chk({nm, "_wr_mask"}, 64'(wm0[k]), 64'(gm));
            end
        end
        chk({nm, "_tag_idx"}, 64'(tag_idx0), 64'd8);
        chk({nm, "_tag_mask"}, 64'(tag_m0), 64'(gm));
        chk({nm, "_data_tag_err"}, 64'(bad0), 64'd0);
        chk({nm, "_busy_after"}, 64'(busy_after0), 64'd0);
        chk({nm, "_grant_after"}, 64'(grant_after0), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus0.miss = '0; bus0.miss_addr = '0; bus0.mem_data = '0; bus0.mem_data_valid = 1'b0;
        bus1.miss = '0; bus1.miss_addr = '0; bus1.mem_data = '0; bus1.mem_data_valid = 1'b0;
        en_p0 = '0; en_p1 = '0; a_p0 = '{16'h0, 16'h0}; a_p1 = '{16'h0, 16'h0}; stray0 = 0;
        clear_logs();

        // Reset values
        cycle();
        cycle();
        chk("rst_out0", 64'({bus0.grant, bus0.busy, bus0.write_data_array, bus0.write_tag_array,
                             bus0.word_num, bus0.mem_en, bus0.mem_addr}), 64'd0);
        chk("rst_out1", 64'({bus1.grant, bus1.busy, bus1.write_data_array, bus1.write_tag_array,
                             bus1.word_num, bus1.mem_en, bus1.mem_addr}), 64'd0);
        rst = 1'b0;
        cycle();

        // Single D-cache miss at 0x1236
        clear_logs();
        bus0.miss_addr = {16'h0000, 16'h1236};
        bus0.miss      = 2'b01;
        cycle();
        chk("d1_grant", 64'(bus0.grant), 64'd1);
        chk("d1_busy", 64'(bus0.busy), 64'd1);
        chk("d1_first_en", 64'(bus0.mem_en), 64'd1);
        chk("d1_first_addr", 64'(bus0.mem_addr), 64'(CWF ? 16'h1236 : 16'h1230));
        wait_tag(0, 40);
        bus0.miss = 2'b00;
        check_fill0("d1", 16'h1236, 2'b01);
        chk("d1_last_addr", 64'(iss0[7]), 64'(CWF ? 16'h1234 : 16'h123E));
        chk("d1_tag_word", 64'(wn0[7]), 64'(CWF ? 3'd2 : 3'd7));

        // Simultaneous misses: port 0 first, port 1 after the IDLE gap
        cycle();
        cycle();
        clear_logs();
        bus0.miss_addr = {16'h2002, 16'h0040};
        bus0.miss      = 2'b11;
        cycle();
        chk("d2_grant_p0", 64'(bus0.grant), 64'd1);
        wait_tag(0, 40);
        bus0.miss = 2'b10;
        check_fill0("d2a", 16'h0040, 2'b01);
        clear_logs();
        cycle();
        chk("d2_grant_p1", 64'(bus0.grant), 64'd2);
        chk("d2_busy_p1", 64'(bus0.busy), 64'd1);
        chk("d2_p1_addr", 64'(bus0.mem_addr), 64'(CWF ? 16'h2002 : 16'h2000));
        wait_tag(0, 40);
        bus0.miss = 2'b00;
        check_fill0("d2b", 16'h2002, 2'b10);

        // Reset at the 4th return, then stray returns
        cycle();
        cycle();
        clear_logs();
        bus0.miss_addr = {16'h0000, 16'h0100};
        bus0.miss      = 2'b01;
        wait_wr(4, 40);
        rst       = 1'b1;
        bus0.miss = 2'b00;
        clear_logs();
        cycle();
        chk("rst_mid_out", 64'({bus0.grant, bus0.busy, bus0.write_data_array, bus0.write_tag_array,
                                bus0.word_num, bus0.mem_en, bus0.mem_addr}), 64'd0);
        rst    = 1'b0;
        stray0 = 3;
        for (int i = 0; i < 6; i++) cycle();
        chk("stray_wr", 64'(wm0.size()), 64'd0);
        chk("stray_tag", 64'(tag_idx0), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("stray_issue", 64'(iss0.size()), 64'd0);
        chk("stray_busy", 64'(bus0.busy), 64'd0);
        clear_logs();
        bus0.miss = 2'b01;
        wait_tag(0, 40);
        bus0.miss = 2'b00;
        check_fill0("d3", 16'h0100, 2'b01);

        // Winner drops miss after two returns
        cycle();
        cycle();
        clear_logs();
        bus0.miss_addr = {16'h0000, 16'h0300};
        bus0.miss      = 2'b01;
        wait_wr(2, 40);
        bus0.miss = 2'b00;
        wait_tag(0, 40);
        check_fill0("d4", 16'h0300, 2'b01);
        cycle();
        chk("d4_idle_busy", 64'(bus0.busy), 64'd0);

        // 4-word block, miss at 0xFFFA
        clear_logs();
        bus1.miss_addr = {16'h0000, 16'hFFFA};
        bus1.miss      = 2'b01;
        cycle();
        chk("w4_grant", 64'(bus1.grant), 64'd1);
        wait_tag(1, 40);
        bus1.miss = 2'b00;
        chk("w4_n_issue", 64'(iss1.size()), 64'd4);
        chk("w4_en_run", 64'(en_last1 - en_first1 + 1), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < iss1.size()) chk("w4_addr", 64'(iss1[k]), 64'(exp_addr(16'hFFFA, 4, k)));
            if (k < wn1.size()) chk("w4_word_num", 64'(wn1[k]), 64'(exp_wn(16'hFFFA, 4, k)));
        end
        chk("w4_first_addr", 64'(iss1[0]), 64'(CWF ? 16'hFFFA : 16'hFFF8));
        chk("w4_last_addr", 64'(iss1[3]), 64'(CWF ? 16'hFFF8 : 16'hFFFE));
        chk("w4_n_wr", 64'(wn1.size()), 64'd4);
        chk("w4_tag_idx", 64'(tag_idx1), 64'd4);
        chk("w4_tag_mask", 64'(tag_m1), 64'd1);
        chk("w4_data_tag_err", 64'(bad1), 64'd0);
        chk("w4_busy_after", 64'(busy_after1), 64'd0);
        chk("w4_d0_quiet", 64'(wm0.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Parametrised successor to the two-cache fill FSM: one fill engine shared by NUM_PORTS caches (port 0 = D-cache, port 1 = I-cache by default), with block size and widths set by parameters.
- Arbitrates pending misses and latches the winner's address.
- Issues one memory read per cycle for every word of the block.
- Steers returned words into the winner's data array and writes its tag on the last word.
- Sits between the caches and the pipelined main memory (memory4c-style data_valid interface).

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width; one word = 2 bytes.
- WORDS_PER_BLOCK, 8, words per cache block; power of two, range 2..64.
- NUM_PORTS, 2, number of requesting caches; range 1..8.
- Derived: WN_W = $clog2(WORDS_PER_BLOCK); OFF_W = WN_W+1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- miss  in  NUM_PORTS  per-port miss request; held high by the cache until its tag is written.
- miss_addr  in  NUM_PORTS*ADDR_W  per-port miss byte address; port i occupies bits [i*ADDR_W +: ADDR_W].
- grant  out  NUM_PORTS  one-hot; port currently being filled.
- busy  out  1  fill in progress.
- write_data_array  out  NUM_PORTS  per-port data-array write strobe.
- write_tag_array  out  NUM_PORTS  per-port tag write strobe.
- word_num  out  WN_W  word index within the block for the current data write.
- fill_data  out  DATA_W  word to write; equals mem_data.
- mem_en  out  1  memory read request.
- mem_addr  out  ADDR_W  memory read byte address.
- mem_data  in  DATA_W  memory read data.
- mem_data_valid  in  1  mem_data valid; one pulse per issued read, in order, after any fixed latency.

Behaviour:
- Reset (synchronous, active-high) puts the FSM in IDLE and clears all counters. All outputs are 0 at reset: grant, busy, write_data_array, write_tag_array, word_num, mem_en, mem_addr.
- FSM states: IDLE, FILL.
- IDLE:
  - When any miss bit is high, grant the lowest-index asserted port (fixed priority).
  - Latch base = miss_addr[p] with bits [OFF_W-1:0] cleared.
  - Set grant and busy the following cycle and enter FILL.
- FILL, issue side:
  - mem_en = 1 for exactly WORDS_PER_BLOCK consecutive cycles, starting the first FILL cycle.
  - mem_addr = base + 2*issue_cnt; issue_cnt runs 0..WORDS_PER_BLOCK-1.
  - mem_en = 0 once all reads are issued.
- FILL, return side:
  - On each mem_data_valid: write_data_array[p] = 1, word_num = ret_cnt, fill_data = mem_data; then ret_cnt increments.
  - Issue and return sides overlap; no stall waiting on the return side.
- Completion:
  - On the valid with ret_cnt = WORDS_PER_BLOCK-1, also assert write_tag_array[p] in the same cycle.
  - Next cycle: IDLE, busy = 0, grant = 0.
  - A new grant cannot occur until the cycle after that. There is a mandatory 1-cycle IDLE gap so the cache lookup sees the new tag and drops miss.
- Strobes for ports other than p are always 0.
- Miss arriving while busy: ignored until IDLE. The loser's miss stays high and it is granted next.
- Winner's miss deasserting mid-fill: the fill still completes; the block and tag are written.
- mem_data_valid in IDLE, or after all returns: ignored, no strobes.
- Reset mid-fill: abort immediately and return to IDLE. Memory returns still in flight after reset are ignored by the IDLE rule.
- Address arithmetic wraps modulo 2^ADDR_W.
- The offset never carries into the tag/index bits, because base is block-aligned.

Optional Feature:
- Macro: CACHE_FILL_CWF_EN (critical word first).
- Defined:
  - start = miss_addr[p][OFF_W-1:1].
  - Issue order is (start + k) mod WORDS_PER_BLOCK, for k = 0..WORDS_PER_BLOCK-1.
  - word_num on return follows the same wrapped order.
  - The tag is written with the last (k = WORDS_PER_BLOCK-1) return.
- Undefined: start = 0, i.e. linear order, as in the FILL description above.

Test Plan:
- Single D miss, defaults, miss_addr[0] = 0x1236:
  - mem_addr 0x1230, 0x1232, … 0x123E on 8 consecutive cycles, mem_en high for exactly 8 cycles.
  - 8 write_data_array[0] pulses with word_num 0..7.
  - write_tag_array[0] coincident with word 7; busy low the next cycle.
- Simultaneous miss[0] and miss[1] (addrs 0x0040 / 0x2002):
  - Port 0 filled first from 0x0040.
  - Port 1 granted after the IDLE gap, base 0x2000.
  - No port-1 strobes during the port-0 fill.
- Reset asserted at the 4th return of a fill, then 3 stray mem_data_valid pulses:
  - All outputs 0 the cycle after reset.
  - Stray pulses produce no strobes.
  - A subsequent miss starts a clean fill from word 0.
- WORDS_PER_BLOCK = 4, miss at 0xFFFA:
  - base 0xFFF8; addresses 0xFFF8..0xFFFE.
  - word_num is 2 bits; tag written on the 4th return.
- Winner's miss deasserted after 2 returns: all 8 data writes plus the tag write still occur.
- CACHE_FILL_CWF_EN defined, miss at 0x1236:
  - Issue order 0x1236, 0x1238, 0x123A, 0x123C, 0x123E, 0x1230, 0x1232, 0x1234.
  - word_num 3, 4, 5, 6, 7, 0, 1, 2; tag written with word 2.
